// File: rtl/mathbox_sequencer.sv
// rtl/mathbox_sequencer.sv - Math Box microprogram sequencer (microcode ROM address side)
//
// Ports:
//   CLK, RST_N           clock, asynchronous active-low reset
//   CPU_WR, CPU_AD       one-cycle command strobe and its register-select index
//   START_ADDR           start-address PROM output for CPU_AD, valid with CPU_WR
//   UC_STOP, UC_JMP      stop / jump fields of the word currently addressed by PC
//   UC_JCOND, UC_TARGET  jump condition select (1 = on FLAG) and jump target
//   FLAG                 ALU condition flag, sampled with the current word
//   PC                   registered microcode ROM address
//   CMD                  CPU_AD latched on the last accepted command
//   RUN                  executing / CPU busy status
//   DONE                 one-cycle pulse after execution ends
//   TIMEOUT              sticky: last program hit the executed-word limit
module mathbox_sequencer #(
    parameter int PC_W      = 8,
    parameter int MAX_STEPS = 1024
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            CPU_WR,
    input  logic [4:0]      CPU_AD,
    input  logic [PC_W-1:0] START_ADDR,
    input  logic            UC_STOP,
    input  logic            UC_JMP,
    input  logic            UC_JCOND,
    input  logic [PC_W-1:0] UC_TARGET,
    input  logic            FLAG,
    output logic [PC_W-1:0] PC,
    output logic [4:0]      CMD,
    output logic            RUN,
    output logic            DONE,
    output logic            TIMEOUT
);

    localparam int STEP_W = $clog2(MAX_STEPS);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic [4:0]        cmd_nxt;
    logic [STEP_W-1:0] step, step_nxt;
    logic              done_nxt;
    logic              timeout_nxt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            PC      <= '0;
            CMD     <= '0;
            step    <= '0;
            DONE    <= 1'b0;
            TIMEOUT <= 1'b0;
        end else begin
            state   <= state_nxt;
            PC      <= pc_nxt;
            CMD     <= cmd_nxt;
            step    <= step_nxt;
            DONE    <= done_nxt;
            TIMEOUT <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = PC;
        cmd_nxt     = CMD;
        step_nxt    = step;
        done_nxt    = 1'b0;
        timeout_nxt = TIMEOUT;

        if (CPU_WR) begin
            // A command always (re)starts, discarding whatever word is current.
            state_nxt   = S_EXEC;
            pc_nxt      = START_ADDR;
            cmd_nxt     = CPU_AD;
            step_nxt    = '0;
            timeout_nxt = 1'b0;
        end else if (state == S_EXEC) begin
            if (UC_STOP) begin
                state_nxt = S_IDLE;
                done_nxt  = 1'b1;
            end else if (step == STEP_LAST) begin
                // Word limit reached: stop on this word and flag it.
                state_nxt   = S_IDLE;
                done_nxt    = 1'b1;
                timeout_nxt = 1'b1;
            end else begin
                step_nxt = step + STEP_W'(1);
                if (UC_JMP && (!UC_JCOND || FLAG)) begin
                    pc_nxt = UC_TARGET;
                end else begin
                    pc_nxt = PC + PC_W'(1);
                end
            end
        end
    end

    assign RUN = (state == S_EXEC);

endmodule

// File: doc/mathbox_sequencer.md
# mathbox_sequencer

Microprogram sequencer for the Math Box coprocessor. It is the address side of the microcode ROM: it takes a CPU command write, loads the microprogram counter from the start-address PROM, and steps it each clock. It evaluates each fetched word's stop and jump fields, and reports run/done/timeout status back to the CPU. The ROM data it drives feeds the Math Box ALU control blocks.

## Interface
Parameters:
- PC_W, 8, microprogram counter / ROM address width
- MAX_STEPS, 1024, executed-word limit before a forced stop (2..2^16)

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- RST_N  in  1  asynchronous, active-low reset
- CPU_WR  in  1  one-cycle command strobe from the CPU write decode
- CPU_AD  in  5  command (register-select) index, valid with CPU_WR
- START_ADDR  in  PC_W  start-address PROM output for CPU_AD, valid with CPU_WR
- UC_STOP  in  1  stop field of the microcode word currently addressed by PC
- UC_JMP  in  1  jump field of the current word
- UC_JCOND  in  1  1 = jump only if FLAG = 1; 0 = unconditional
- UC_TARGET  in  PC_W  jump target field of the current word
- FLAG  in  1  ALU condition flag, sampled in the same cycle as the word
- PC  out  PC_W  microcode ROM address (registered)
- CMD  out  5  CPU_AD latched on the last accepted CPU_WR
- RUN  out  1  sequencer executing; also the CPU busy status bit
- DONE  out  1  one-cycle pulse when execution ends
- TIMEOUT  out  1  sticky: the last program was force-stopped

## Operation
The sequencer has two states, IDLE and EXEC. RUN = (state == EXEC).

Reset (asynchronous):
- PC = 0, CMD = 0, RUN = 0, DONE = 0, TIMEOUT = 0.
- The step counter is 0 and the state is IDLE.

CPU_WR is accepted in either state:
- PC <= START_ADDR, CMD <= CPU_AD, state <= EXEC.
- Step counter <= 0 and TIMEOUT <= 0.
- In EXEC this is a restart: the current word is discarded and DONE is not pulsed.
- CPU_WR has priority over every microcode field in the same cycle.

In IDLE with no CPU_WR:
- All state holds. UC_* and FLAG are ignored.

In EXEC with no CPU_WR, the current word is evaluated in priority order:
1. UC_STOP = 1: state <= IDLE, DONE pulses, PC holds (it stays on the stop word).
2. Step counter == MAX_STEPS-1: forced stop. State <= IDLE, DONE pulses, TIMEOUT <= 1, PC holds.
3. UC_JMP = 1 and (UC_JCOND = 0 or FLAG = 1): PC <= UC_TARGET.
4. Otherwise: PC <= PC + 1, modulo 2^PC_W (all-ones wraps to 0).

Step counter:
- Increments on every EXEC cycle that does not end execution.
- Width is clog2(MAX_STEPS); it never wraps.

DONE is a single-cycle pulse: high only in the cycle immediately after the ending edge, then low.

TIMEOUT is sticky: it holds until the next accepted CPU_WR or reset.

## Timing
- CPU_WR sampled at edge k: after edge k, RUN = 1 and PC = START_ADDR. The first word is evaluated at edge k+1 (one cycle of start latency).
- A program of N words, with the stop on word N:
  - RUN is high for exactly N cycles.
  - DONE is high during cycle k+N+1.
- A taken jump takes effect on the next cycle; there are no delay slots.
- UC_* and FLAG must be settled before the edge. The ROM is asynchronous from PC, and the sequencer adds no fetch register.
- Reset asserted mid-program clears all outputs immediately. No DONE pulse is generated.

## Test plan
- Reset: hold RST_N low mid-EXEC -> PC = 0, RUN = 0, DONE = 0, TIMEOUT = 0, CMD = 0 without waiting for a clock edge.
- Linear program: CPU_WR with CPU_AD = 5'h03, START_ADDR = 8'h10, stop at 8'h13 -> PC runs 10, 11, 12, 13; RUN is high 4 cycles; DONE is high one cycle after; CMD = 03; TIMEOUT = 0.
- Conditional jump: word 8'h20 has UC_JMP = 1, UC_JCOND = 1, UC_TARGET = 8'h40.
  - FLAG = 0 -> next PC = 8'h21.
  - FLAG = 1 -> next PC = 8'h40.
  - UC_JCOND = 0 -> 8'h40 regardless of FLAG.
- Wrap: START_ADDR = 8'hFE, stop at 8'h01 -> PC sequence FE, FF, 00, 01, then DONE.
- Restart and collision:
  - CPU_WR mid-run with START_ADDR = 8'h80 -> PC = 80 next cycle, RUN stays 1, no DONE.
  - CPU_WR in the same cycle as a stop word -> restart wins, no DONE.
- Timeout: MAX_STEPS = 8, word 8'h05 jumps to itself unconditionally -> RUN is high 8 cycles, then DONE pulses and TIMEOUT = 1 with PC = 05. The next CPU_WR clears TIMEOUT.
